seq_fixed_div: RTL
==================

# seq_fixed_div

Multi-cycle sign-magnitude fixed-point divider (Q(N-Q).Q, default Q16.16) computing c = a / b by restoring long division, one quotient bit per clock. It is the exact counterpart of `mult`. It replaces the Newton-Raphson `div`/`reciprocal` path wherever a truncated-exact quotient is needed, for example neuron conductance or time-constant normalisation. It also trades that path's area for latency. Operands and result use the library format: bit N-1 is the sign, bits N-2:0 are the magnitude.

## Interface
- N, 32, total word width including sign bit
- Q, 16, fractional bits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands a, b valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  N  dividend, sign-magnitude
- b  in  N  divisor, sign-magnitude
- out_valid  out  1  result c and flags valid
- out_ready  in  1  consumer accepts result
- c  out  N  quotient, sign-magnitude, truncated toward zero
- div_by_zero  out  1  divisor magnitude was zero
- overflow  out  1  quotient magnitude exceeded 2^(N-1)-1 LSBs

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid, register sign = a[N-1]^b[N-1], dividend D = {a[N-2:0], Q zeros} (N-1+Q bits), divisor magnitude B = b[N-2:0], remainder R=0, quotient 0, sticky overflow 0, bit counter = N-1+Q.
  - If B==0: go directly to DONE with div_by_zero=1 and c = {sign, all ones}.
  - Otherwise go to RUN.
- RUN: each cycle shifts the next D bit (MSB first) into R.
  - If R ≥ B: R -= B and the quotient bit is 1; otherwise the bit is 0.
  - Any 1 among the first Q bits produced (quotient positions N-2+Q..N-1) sets sticky overflow.
  - Counter decrements. On the cycle processing bit 0, go to DONE.
- DONE: out_valid=1. c, div_by_zero and overflow are held stable until out_ready is sampled high, then go to IDLE.
- Result rules, applied on entry to DONE:
  - If overflow: c = {sign, all ones} (saturate).
  - If the final magnitude is 0: sign bit is forced to 0. No negative zero is ever output.
  - Negative-zero inputs are treated as zero magnitude. A divisor of 0x80000000 triggers div_by_zero.
  - div_by_zero and overflow are never both set.
- in_valid outside IDLE is ignored. Operands are not re-sampled during RUN.

## Timing
- Reset (asynchronous, immediate, in any state): state=IDLE, c=0, out_valid=0, div_by_zero=0, overflow=0, internal registers=0. in_ready is 1 during and after reset.
- Reset mid-RUN or mid-DONE aborts the operation with no output. The next acceptance is possible on the first edge after reset deassertion.
- Acceptance edge = edge where in_valid && in_ready. out_valid rises after edge +(N-1+Q) (47 for defaults) for normal division, or after edge +1 for divide-by-zero.
- Output handshake completes on the edge where out_valid && out_ready. out_valid falls after that edge and in_ready rises in the same cycle.
- Minimum operation period: N+Q+1 cycles (49 for defaults) with out_ready tied high.
- in_ready is a decode of state only. It has no combinational path from in_valid or out_ready.
- All outputs are registered except in_ready.

## Structure
- Shared package `fixed_pkg`:
  - default N, Q
  - FIXED_ONE (1<<Q)
  - FIXED_MAX_MAG ({N-1{1'b1}})
  - enum typedef div_state_t {IDLE, RUN, DONE}
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: R, incoming bit, B.
  - Outputs: next R, quotient bit.
  - Width is N bits, one more than the magnitude, so the trial subtract cannot wrap.
- Top level contains the FSM, counter ($clog2(N+Q) bits), shift registers, sticky overflow and output saturation.

## Test plan
- 6.0/2.0: a=0x00060000, b=0x00020000 -> c=0x00030000, flags 0, out_valid exactly 47 cycles after acceptance.
- -1.0/3.0: a=0x80010000, b=0x00030000 -> c=0x80005555 (truncated), flags 0.
- Divide by zero: a=0x00010000, b=0x00000000 -> c=0x7FFFFFFF, div_by_zero=1, out_valid 1 cycle after acceptance. Repeat with b=0x80000000 -> c=0xFFFFFFFF, div_by_zero=1.
- Overflow: a=0x40000000, b=0x00000100 -> c=0x7FFFFFFF, overflow=1. Underflow to zero: a=0x80000001, b=0x7FFFFFFF -> c=0x00000000 (sign cleared).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> c and flags stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> out_valid falls next edge and in_ready rises.
- Reset mid-RUN: assert reset 20 cycles after acceptance -> outputs zero immediately, in_ready=1. A new 6.0/2.0 accepted after release completes correctly in 47 cycles.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared definitions for the sign-magnitude Q(N-Q).Q fixed-point library.
package fixed_pkg;

  localparam int DEFAULT_N = 32;
  localparam int DEFAULT_Q = 16;

  localparam logic [DEFAULT_N-1:0] FIXED_ONE =
    {{(DEFAULT_N-DEFAULT_Q-1){1'b0}}, 1'b1, {DEFAULT_Q{1'b0}}};
  localparam logic [DEFAULT_N-2:0] FIXED_MAX_MAG = {(DEFAULT_N-1){1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring long-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] r,
  input  logic         bit_in,
  input  logic [W-2:0] b,
  output logic [W-1:0] r_next,
  output logic         q_bit
);

  logic [W-1:0] shifted;
  logic [W-1:0] b_ext;
  logic [W-1:0] trial;

  // The remainder is always below the divisor, so one extra bit keeps the trial subtract from wrapping.
  always_comb begin
    shifted = W'({r, bit_in});
    b_ext   = {1'b0, b};
    trial   = shifted - b_ext;
    if (shifted >= b_ext) begin
      q_bit  = 1'b1;
      r_next = trial;
    end else begin
      q_bit  = 1'b0;
      r_next = shifted;
    end
  end

endmodule

// File: rtl/seq_fixed_div.sv
// Sequential sign-magnitude fixed-point divider: one quotient bit per clock by restoring division.
module seq_fixed_div
  import fixed_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int Q = DEFAULT_Q
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int DW = N - 1 + Q;
  localparam int CW = $clog2(N + Q);

  div_state_t      state;
  logic            sign;
  logic [DW-1:0]   d;
  logic [N-2:0]    b_mag;
  logic [N-1:0]    r;
  logic [N-2:0]    q;
  logic [CW-1:0]   cnt;
  logic            ovf;

  logic [N-1:0]    r_next;
  logic            q_bit;
  logic [N-2:0]    q_next;
  logic            ovf_next;

  function automatic logic [N-1:0] pack_result(input logic s, input logic [N-2:0] mag,
                                               input logic sat);
    logic [N-1:0] res;
    if (sat) begin
      res = {s, {(N-1){1'b1}}};
    end else if (mag == '0) begin
      res = '0;
    end else begin
      res = {s, mag};
    end
    return res;
  endfunction

  div_step #(.W(N)) u_step (
    .r      (r),
    .bit_in (d[DW-1]),
    .b      (b_mag),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // Quotient bits above the integer range only feed the sticky overflow flag.
  always_comb begin
    q_next   = (N-1)'({q, q_bit});
    ovf_next = ovf | (q_bit & (cnt >= CW'(N)));
  end

  assign in_ready = (state == IDLE);

  // Control FSM together with the datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sign        <= 1'b0;
      d           <= '0;
      b_mag       <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      c           <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= a[N-1] ^ b[N-1];
            d     <= {a[N-2:0], {Q{1'b0}}};
            b_mag <= b[N-2:0];
            r     <= '0;
            q     <= '0;
            ovf   <= 1'b0;
            cnt   <= CW'(DW);
            if (b[N-2:0] == '0) begin
              state       <= DONE;
              c           <= {a[N-1] ^ b[N-1], {(N-1){1'b1}}};
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          d   <= {d[DW-2:0], 1'b0};
          r   <= r_next;
          q   <= q_next;
          ovf <= ovf_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= ovf_next;
            c           <= pack_result(sign, q_next, ovf_next);
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          // Divide-by-zero enters DONE with out_valid low and raises it one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
